// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I encoding constants for the instruction encoder.
//   - OPC_*   : opcode[6:2] major-opcode values (opcode[1:0] is always 2'b11)
//   - MEMOP_* : memory-operation class codes carried in memop[4:3]
//   - fmt_e   : instruction format selected from the major opcode
//   - opc_fmt : maps a full 7-bit opcode onto its format (FMT_ILL if unknown)
//   - sext_ok : true when v[31:msb] are all equal (value fits msb+1 signed bits)
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [1:0] MEMOP_LOAD   = 2'b01;
  localparam logic [1:0] MEMOP_STORE  = 2'b10;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } fmt_e;

  function automatic fmt_e opc_fmt(input logic [6:0] opcode);
    fmt_e fmt;
    fmt = FMT_ILL;
    if (opcode[1:0] == 2'b11) begin
      case (opcode[6:2])
        OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM,
        OPC_JALR, OPC_SYSTEM:               fmt = FMT_I;
        OPC_AUIPC, OPC_LUI:                 fmt = FMT_U;
        OPC_STORE:                          fmt = FMT_S;
        OPC_OP:                             fmt = FMT_R;
        OPC_BRANCH:                         fmt = FMT_B;
        OPC_JAL:                            fmt = FMT_J;
        default:                            fmt = FMT_ILL;
      endcase
    end
    return fmt;
  endfunction

  function automatic logic sext_ok(input logic [31:0] v, input int msb);
    logic [31:0] mask;
    logic [31:0] top;
    mask = 32'hFFFF_FFFF << msb;
    top  = v & mask;
    return (top == 32'h0) || (top == mask);
  endfunction

endpackage

// File: rtl/encoder_fifo.sv
// -----------------------------------------------------------------------------
// encoder_fifo
//   Synchronous FIFO holding encoded words between the encoder and its consumer.
//   Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     wr_en, wr_data    push request and data (ignored when full)
//     rd_en             pop request (ignored when empty)
//     rd_data           head entry, forced to zero while empty
//     full, empty       occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module encoder_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // NOTE: every combinational output gets a default before any branch, so no
  // path through the block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count alone decides
  // which entries are meaningful, and rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/insn_encoder.sv
// -----------------------------------------------------------------------------
// insn_encoder
//   Packs decoded RV32I fields back into a 32-bit instruction word. The word is
//   built combinationally from the inputs and pushed into an output FIFO on
//   accept, so out_valid rises one cycle after the accepting edge.
//   Parameters: DEPTH (output FIFO entries), CNT_W (illegal counter width).
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     in_valid / in_ready        request handshake (in_ready = FIFO not full)
//     in_opcode, in_rd, in_rs1,
//     in_rs2, in_func, in_imm,
//     in_memop                   decoded fields in decoder conventions
//     out_valid / out_ready      FIFO head handshake
//     out_insn, out_illegal      head word (zero when illegal) and its flag
//     illegal_cnt                saturating count of accepted illegal requests
//   Build option: define ENCODER_RANGE_CHECK_EN to also flag immediates that do
//   not fit their field and LOAD/STORE requests with the wrong memop class.
//   Without it, out-of-range immediate bits are silently truncated.
// -----------------------------------------------------------------------------
module insn_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [14:0]      in_func,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_memop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_insn,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  fmt_e             fmt;
  logic [4:0]       op5;
  logic             is_shift;
  logic [2:0]       funct3;
  logic [11:0]      imm12;
  logic             range_bad;
  logic [31:0]      enc_insn;
  logic             enc_illegal;
  logic             accept;
  logic             fifo_full, fifo_empty;
  logic [32:0]      head;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op5 = in_opcode[6:2];

  always_comb begin
    fmt = opc_fmt(in_opcode);

    // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry funct7 in the upper bits.
    is_shift = (op5 == OPC_OP_IMM) && (in_func[1:0] == 2'b01);

    funct3 = in_func[2:0];
    if (op5 == OPC_LOAD || op5 == OPC_STORE) funct3 = in_memop[2:0];
    else if (op5 == OPC_JALR)                funct3 = 3'b000;

    // I-type upper field: FENCE/SYSTEM take it from func, shifts split it.
    imm12 = in_imm[11:0];
    if (op5 == OPC_MISC_MEM || op5 == OPC_SYSTEM) imm12 = in_func[14:3];
    else if (is_shift)                            imm12 = {in_func[9:3], in_imm[4:0]};

    case (fmt)
      FMT_R:   enc_insn = {in_func[9:3], in_rs2, in_rs1, funct3, in_rd, in_opcode};
      FMT_I:   enc_insn = {imm12, in_rs1, funct3, in_rd, in_opcode};
      FMT_S:   enc_insn = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], in_opcode};
      FMT_B:   enc_insn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
      FMT_U:   enc_insn = {in_imm[31:12], in_rd, in_opcode};
      FMT_J:   enc_insn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, in_opcode};
      default: enc_insn = 32'h0;
    endcase

    range_bad = 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
    case (fmt)
      FMT_I: begin
        if (is_shift)
          range_bad = |in_imm[31:5];
        else if (op5 != OPC_MISC_MEM && op5 != OPC_SYSTEM)
          range_bad = !sext_ok(in_imm, 11);
        if (op5 == OPC_LOAD && in_memop[4:3] != MEMOP_LOAD) range_bad = 1'b1;
      end
      FMT_S:   range_bad = !sext_ok(in_imm, 11) || (in_memop[4:3] != MEMOP_STORE);
      FMT_B:   range_bad = !sext_ok(in_imm, 12) || in_imm[0];
      FMT_J:   range_bad = !sext_ok(in_imm, 20) || in_imm[0];
      FMT_U:   range_bad = |in_imm[11:0];
      default: range_bad = 1'b0;
    endcase
`endif

    enc_illegal = (fmt == FMT_ILL) || range_bad;
    if (enc_illegal) enc_insn = 32'h0;
  end

`ifndef ENCODER_RANGE_CHECK_EN
  // The memop class only matters when range checking is built in.
  logic unused_memop_class;
  assign unused_memop_class = ^in_memop[4:3];
`endif

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && enc_illegal && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  encoder_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data ({enc_illegal, enc_insn}),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign out_illegal = head[32];
  assign out_insn    = head[31:0];
  assign illegal_cnt = cnt_q;

endmodule
